// File: rtl/act_pkg.sv
// Shared types for the activation bus unit: activation modes and config FSM states.
package act_pkg;

  typedef enum logic [1:0] {
    ACT_BYPASS = 2'd0,
    ACT_RELU   = 2'd1,
    ACT_CLIP   = 2'd2,
    ACT_LEAKY  = 2'd3
  } act_mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } act_state_e;

endpackage

// File: rtl/act_lane.sv
// Single-lane activation (bypass / relu / clip / leaky) with lane masking.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module act_lane
  import act_pkg::*;
#(
  parameter int IDATA_BIT = 8,
  parameter int SHIFT_BIT = 3
) (
  input  logic [IDATA_BIT-1:0] x,
  input  logic [1:0]           mode,
  input  logic [IDATA_BIT-2:0] clip,
  input  logic [SHIFT_BIT-1:0] shift,
  input  logic                 mask,
  output logic [IDATA_BIT-1:0] y,
  output logic                 is_zero
);

  logic signed [IDATA_BIT-1:0] xs;
  logic signed [IDATA_BIT-1:0] clip_s;
  logic signed [IDATA_BIT-1:0] res;

  assign xs     = $signed(x);
  assign clip_s = $signed({1'b0, clip});

  always_comb begin
    res = xs;
    case (act_mode_e'(mode))
      ACT_BYPASS: res = xs;
      ACT_RELU:   res = xs[IDATA_BIT-1] ? '0 : xs;
      ACT_CLIP: begin
        if (xs[IDATA_BIT-1])   res = '0;
        else if (xs > clip_s)  res = clip_s;
        else                   res = xs;
      end
      // Arithmetic shift floors, so small negatives settle at -1 rather than 0.
      ACT_LEAKY:  res = xs[IDATA_BIT-1] ? (xs >>> shift) : xs;
    endcase
  end

  assign y       = mask ? res : '0;
  assign is_zero = mask && (res == '0);

endmodule

// File: rtl/act_bus_unit.sv
// Multi-lane activation unit with runtime mode, shadowed config and zero-output counter.
// Latency: 2 cycles (S1 compute register, S2 output register), 1 beat/cycle.
// Backpressure: valid/ready both sides; in_ready follows out_ready combinationally, held low while draining for a config change.
module act_bus_unit
  import act_pkg::*;
#(
  parameter int BUS_NUM   = 4,
  parameter int IDATA_BIT = 8,
  parameter int SHIFT_BIT = 3,
  parameter int CNT_BIT   = 16
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic [1:0]                     cfg_mode,
  input  logic [IDATA_BIT-2:0]           cfg_clip,
  input  logic [SHIFT_BIT-1:0]           cfg_shift,
  input  logic                           cfg_load,
  output logic                           cfg_pending,
  input  logic [BUS_NUM*IDATA_BIT-1:0]   in_data,
  input  logic [BUS_NUM-1:0]             in_mask,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [BUS_NUM*IDATA_BIT-1:0]   out_data,
  output logic [BUS_NUM-1:0]             out_mask,
  output logic                           out_valid,
  input  logic                           out_ready,
  input  logic                           cnt_clr,
  output logic [CNT_BIT-1:0]             zero_cnt
);

  localparam int DW = BUS_NUM * IDATA_BIT;

  act_state_e state;

  logic [1:0]           sh_mode,  cap_mode,  eff_mode;
  logic [IDATA_BIT-2:0] sh_clip,  cap_clip,  eff_clip;
  logic [SHIFT_BIT-1:0] sh_shift, cap_shift, eff_shift;

  logic               s1_valid;
  logic [DW-1:0]      s1_data;
  logic [BUS_NUM-1:0] s1_mask;
  logic [BUS_NUM-1:0] s1_zero;
  logic [BUS_NUM-1:0] s2_zero;

  logic               s2_load, s1_adv, accept, apply_now, pipe_empty;
  logic [DW-1:0]      lane_y;
  logic [BUS_NUM-1:0] lane_zero;
  logic [CNT_BIT:0]   zsum;

  assign s2_load    = !out_valid || out_ready;
  assign s1_adv     = !s1_valid || s2_load;
  assign in_ready   = s1_adv && (state != DRAIN);
  assign accept     = in_valid && in_ready;
  assign pipe_empty = !s1_valid && !out_valid;

  // A load in IDLE takes effect for a beat accepted in the same cycle.
  assign apply_now = (state == IDLE) && cfg_load;
  assign eff_mode  = apply_now ? cfg_mode  : sh_mode;
  assign eff_clip  = apply_now ? cfg_clip  : sh_clip;
  assign eff_shift = apply_now ? cfg_shift : sh_shift;

  generate
    for (genvar i = 0; i < BUS_NUM; i++) begin : g_lane
      act_lane #(
        .IDATA_BIT (IDATA_BIT),
        .SHIFT_BIT (SHIFT_BIT)
      ) u_lane (
        .x       (in_data[i*IDATA_BIT +: IDATA_BIT]),
        .mode    (eff_mode),
        .clip    (eff_clip),
        .shift   (eff_shift),
        .mask    (in_mask[i]),
        .y       (lane_y[i*IDATA_BIT +: IDATA_BIT]),
        .is_zero (lane_zero[i])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid  <= 1'b0;
      s1_data   <= '0;
      s1_mask   <= '0;
      s1_zero   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_mask  <= '0;
      s2_zero   <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid <= accept;
        if (accept) begin
          s1_data <= lane_y;
          s1_mask <= in_mask;
          s1_zero <= lane_zero;
        end
      end
      if (s2_load) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_data <= s1_data;
          out_mask <= s1_mask;
          s2_zero  <= s1_zero;
        end
      end
    end
  end

  // Headroom of one extra bit is enough as long as BUS_NUM < 2**CNT_BIT.
  always_comb begin
    zsum = {1'b0, zero_cnt};
    for (int i = 0; i < BUS_NUM; i++) begin
      zsum = zsum + (CNT_BIT+1)'(s2_zero[i]);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      zero_cnt <= '0;
    end else if (cnt_clr) begin
      zero_cnt <= '0;
    end else if (out_valid && out_ready) begin
      zero_cnt <= zsum[CNT_BIT] ? '1 : zsum[CNT_BIT-1:0];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      cfg_pending <= 1'b0;
      sh_mode     <= '0;
      sh_clip     <= '0;
      sh_shift    <= '0;
      cap_mode    <= '0;
      cap_clip    <= '0;
      cap_shift   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cfg_load) begin
            sh_mode  <= cfg_mode;
            sh_clip  <= cfg_clip;
            sh_shift <= cfg_shift;
          end
          if (accept) state <= RUN;
        end
        RUN: begin
          if (cfg_load) begin
            cap_mode    <= cfg_mode;
            cap_clip    <= cfg_clip;
            cap_shift   <= cfg_shift;
            cfg_pending <= 1'b1;
            state       <= DRAIN;
          end else if (pipe_empty && !accept) begin
            state <= IDLE;
          end
        end
        DRAIN: begin
          if (pipe_empty) begin
            // A load arriving on the drain-complete cycle is the latest request.
            sh_mode     <= cfg_load ? cfg_mode  : cap_mode;
            sh_clip     <= cfg_load ? cfg_clip  : cap_clip;
            sh_shift    <= cfg_load ? cfg_shift : cap_shift;
            cfg_pending <= 1'b0;
            state       <= IDLE;
          end else if (cfg_load) begin
            cap_mode  <= cfg_mode;
            cap_clip  <= cfg_clip;
            cap_shift <= cfg_shift;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_act_bus_unit.sv
// Directed plus randomized bench for act_bus_unit with a queue-based reference model.
module tb_act_bus_unit;

  localparam int NB = 4;
  localparam int W  = 8;
  localparam int CB = 16;

  logic            clk = 1'b0;
  logic            rstn;
  logic [1:0]      cfg_mode;
  logic [W-2:0]    cfg_clip;
  logic [2:0]      cfg_shift;
  logic            cfg_load;
  logic            cfg_pending;
  logic [NB*W-1:0] in_data;
  logic [NB-1:0]   in_mask;
  logic            in_valid;
  logic            in_ready;
  logic [NB*W-1:0] out_data;
  logic [NB-1:0]   out_mask;
  logic            out_valid;
  logic            out_ready;
  logic            cnt_clr;
  logic [CB-1:0]   zero_cnt;

  always #5 clk = ~clk;

  act_bus_unit #(.BUS_NUM(NB), .IDATA_BIT(W), .SHIFT_BIT(3), .CNT_BIT(CB)) dut (
    .clk(clk), .rstn(rstn),
    .cfg_mode(cfg_mode), .cfg_clip(cfg_clip), .cfg_shift(cfg_shift),
    .cfg_load(cfg_load), .cfg_pending(cfg_pending),
    .in_data(in_data), .in_mask(in_mask), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_mask(out_mask), .out_valid(out_valid), .out_ready(out_ready),
    .cnt_clr(cnt_clr), .zero_cnt(zero_cnt)
  );

  int checks = 0;
  int failures = 0;
  int m_mode = 0, m_clip = 0, m_shift = 0;
  int exp_zero = 0;
  int n_out = 0;
  logic [31:0] last_out;
  logic [3:0]  last_mask;
  logic [31:0] exp_q[$];
  logic [3:0]  expm_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Activation defined on plain integers; leaky uses floor division.
  function automatic int act_ref(int x, int mode, int clip, int sh);
    int d, q;
    case (mode)
      0: return x;
      1: return (x < 0) ? 0 : x;
      2: return (x < 0) ? 0 : ((x > clip) ? clip : x);
      default: begin
        if (x >= 0) return x;
        d = 1 << sh;
        q = x / d;
        if (q * d != x) q = q - 1;
        return q;
      end
    endcase
  endfunction

  function automatic logic [31:0] pk(int a, int b, int c, int d);
    return {d[7:0], c[7:0], b[7:0], a[7:0]};
  endfunction

  always @(negedge clk) begin
    logic [31:0] e, got;
    logic [3:0]  em;
    int x, y, z;
    if (!rstn) begin
      exp_q.delete();
      expm_q.delete();
      exp_zero = 0;
    end else begin
      chk("zero_cnt", zero_cnt, 64'(exp_zero));
      z = 0;
      if (out_valid && out_ready) begin
        chk("sb_nonempty", exp_q.size() != 0, 1);
        got = out_data;
        last_out = out_data;
        last_mask = out_mask;
        n_out++;
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          em = expm_q.pop_front();
          chk("out_data", got, e);
          chk("out_mask", out_mask, em);
          for (int i = 0; i < NB; i++)
            if (em[i] && e[i*8 +: 8] == 8'd0) z++;
        end
      end
      if (cnt_clr) exp_zero = 0;
      else exp_zero = (exp_zero + z > 65535) ? 65535 : exp_zero + z;
      if (in_valid && in_ready) begin
        for (int i = 0; i < NB; i++) begin
          x = $signed(in_data[i*8 +: 8]);
          y = in_mask[i] ? act_ref(x, m_mode, m_clip, m_shift) : 0;
          e[i*8 +: 8] = y[7:0];
        end
        exp_q.push_back(e);
        expm_q.push_back(in_mask);
      end
    end
  end

  task automatic set_cfg(input int md, input int cl, input int sh);
    cfg_mode = md[1:0]; cfg_clip = cl[6:0]; cfg_shift = sh[2:0];
    cfg_load = 1'b1;
    m_mode = md; m_clip = cl; m_shift = sh;
    @(posedge clk); #1;
    cfg_load = 1'b0;
  endtask

  task automatic wait_idle();
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic [3:0] m);
    int k;
    in_data = d; in_mask = m; in_valid = 1'b1;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("send_timeout", k < 100, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int target, input string tag);
    int k;
    k = 0;
    while (n_out < target && k < 100) begin
      @(negedge clk); #1;
      k++;
    end
    chk(tag, n_out >= target, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    int n0, k;
    rstn = 1'b0; cfg_mode = '0; cfg_clip = '0; cfg_shift = '0; cfg_load = 1'b0;
    in_data = '0; in_mask = '0; in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_mask", out_mask, 0);
    chk("rst_zero_cnt", zero_cnt, 0);
    chk("rst_pending", cfg_pending, 0);
    #13 rstn = 1'b1;
    @(posedge clk); #1;
    chk("idle_in_ready", in_ready, 1);

    // ReLU with exact 2-cycle latency
    set_cfg(1, 0, 0);
    in_data = pk(-5, 0, 7, -128); in_mask = 4'hF; in_valid = 1'b1;
    @(negedge clk); chk("relu_in_ready", in_ready, 1);
    @(posedge clk); #1; in_valid = 1'b0;
    @(negedge clk); chk("relu_lat1", out_valid, 0);
    @(negedge clk); chk("relu_lat2", out_valid, 1);
    chk("relu_data", out_data, pk(0, 0, 7, 0));
    @(posedge clk); #1;
    @(negedge clk); chk("relu_zero_cnt", zero_cnt, 3);
    @(posedge clk); #1;

    // Clip, config loaded in the same cycle as the beat
    wait_idle();
    cfg_mode = 2'd2; cfg_clip = 7'd20; cfg_shift = 3'd0; cfg_load = 1'b1;
    m_mode = 2; m_clip = 20; m_shift = 0;
    n0 = n_out;
    send(pk(25, -3, 20, 19), 4'hF);
    cfg_load = 1'b0;
    wait_out(n0 + 1, "clip_timeout");
    chk("clip_data", last_out, pk(20, 0, 20, 19));

    wait_idle();
    set_cfg(3, 0, 2);
    n0 = n_out;
    send(pk(-8, -1, 12, -128), 4'hF);
    wait_out(n0 + 1, "leaky_timeout");
    chk("leaky_data", last_out, pk(-2, -1, 12, -32));

    wait_idle();
    set_cfg(0, 0, 0);
    n0 = n_out;
    send(pk(9, 9, -9, 9), 4'b0101);
    wait_out(n0 + 1, "mask_timeout");
    chk("mask_data", last_out, pk(9, 0, -9, 0));
    chk("mask_mask", last_mask, 4'b0101);
    chk("mask_zero_cnt", zero_cnt, 4);

    // Backpressure: out_ready low for three cycles
    wait_idle();
    n0 = n_out;
    out_ready = 1'b0;
    in_valid = 1'b1; in_mask = 4'hF; in_data = pk(1, 2, 3, 4);
    @(negedge clk); chk("bp_acc0", in_ready, 1);
    @(posedge clk); #1; in_data = pk(5, 6, 7, 8);
    @(negedge clk); chk("bp_acc1", in_ready, 1);
    @(posedge clk); #1; in_data = pk(9, 10, 11, 12);
    @(negedge clk); chk("bp_full", in_ready, 0);
    @(posedge clk); #1; out_ready = 1'b1;
    @(negedge clk); chk("bp_resume", in_ready, 1);
    @(posedge clk); #1;
    send(pk(13, 14, 15, 16), 4'hF);
    wait_out(n0 + 4, "bp_timeout");
    wait_idle();
    chk("bp_count", n_out, n0 + 4);
    chk("bp_last", last_out, pk(13, 14, 15, 16));
    chk("bp_sb_empty", exp_q.size(), 0);

    // Config change with two beats in flight
    set_cfg(1, 0, 0);
    n0 = n_out;
    in_valid = 1'b1; in_mask = 4'hF; in_data = pk(-1, 2, -3, 4);
    @(posedge clk); #1; in_data = pk(-7, -7, 5, 0);
    @(posedge clk); #1;
    in_valid = 1'b0; cfg_mode = 2'd0; cfg_load = 1'b1; m_mode = 0;
    @(posedge clk); #1;
    cfg_load = 1'b0; cfg_mode = 2'd3;
    in_valid = 1'b1; in_data = pk(-4, -4, -4, -4);
    @(negedge clk);
    chk("drain_pending", cfg_pending, 1);
    chk("drain_in_ready", in_ready, 0);
    k = 0;
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("drain_timeout", k < 50, 1);
    chk("drain_pending_clr", cfg_pending, 0);
    @(posedge clk); #1; in_valid = 1'b0;
    wait_out(n0 + 3, "drain_out_timeout");
    chk("drain_new_beat", last_out, pk(-4, -4, -4, -4));

    // Randomized bursts under random backpressure
    for (int r = 0; r < 4; r++) begin
      wait_idle();
      set_cfg($urandom_range(0, 3), $urandom_range(0, 127), $urandom_range(0, 7));
      repeat (60) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data = $urandom;
        if ($urandom_range(0, 7) == 0) in_data[7:0] = 8'h80;
        in_mask = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom_range(0, 15));
        out_ready = ($urandom_range(0, 3) != 0);
        @(posedge clk); #1;
      end
      wait_idle();
      chk("rand_drain", exp_q.size(), 0);
    end

    // Reset while a beat is presented at the output
    wait_idle();
    out_ready = 1'b0;
    send(pk(3, 0, 3, 3), 4'hF);
    @(posedge clk); #1;
    chk("rst_pre_valid", out_valid, 1);
    #1 rstn = 1'b0;
    #1;
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_zero_cnt", zero_cnt, 0);
    chk("rst_mid_pending", cfg_pending, 0);
    @(negedge clk); #1;
    rstn = 1'b1;
    m_mode = 0; m_clip = 0; m_shift = 0;
    out_ready = 1'b1;
    @(posedge clk); #1;

    // Saturation, then clear colliding with an increment
    set_cfg(1, 0, 0);
    in_data = '0; in_mask = 4'hF; in_valid = 1'b1; out_ready = 1'b1;
    repeat (16400) @(posedge clk);
    #1;
    chk("sat_zero_cnt", zero_cnt, 16'hFFFF);
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    chk("clr_priority", zero_cnt, 0);
    wait_idle();
    chk("final_sb_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/act_bus_unit.md
Name: act_bus_unit

Overview:
- Multi-lane pipelined activation unit. It replaces the single-mode relu instance that sits after the core_array output bus.
- Applies one runtime-selected activation to BUS_NUM signed lanes per beat: bypass, ReLU, clipped ReLU or leaky ReLU.
- Uses valid/ready backpressure on both sides.
- Configuration is shadowed and applied only on beat boundaries with the pipeline drained.
- Keeps a saturating count of zero outputs for sparsity statistics.

Parameters:
- BUS_NUM, 4: number of parallel lanes.
- IDATA_BIT, 8: signed lane width, identical for input and output.
- SHIFT_BIT, 3: width of the leaky shift amount.
- CNT_BIT, 16: width of the zero-output counter.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- cfg_mode  in  2  activation mode: 0 bypass, 1 relu, 2 clip, 3 leaky.
- cfg_clip  in  IDATA_BIT-1  unsigned upper bound for clip mode.
- cfg_shift  in  SHIFT_BIT  arithmetic right-shift for negative inputs in leaky mode.
- cfg_load  in  1  single-cycle request to latch the cfg_* inputs.
- cfg_pending  out  1  a load is waiting for the pipeline to drain.
- in_data  in  BUS_NUM*IDATA_BIT  signed lanes; lane i occupies bits [i*IDATA_BIT +: IDATA_BIT].
- in_mask  in  BUS_NUM  per-lane valid mask.
- in_valid  in  1  beat valid.
- in_ready  out  1  unit accepts the beat.
- out_data  out  BUS_NUM*IDATA_BIT  activated lanes.
- out_mask  out  BUS_NUM  registered copy of in_mask.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- cnt_clr  in  1  synchronous clear of zero_cnt.
- zero_cnt  out  CNT_BIT  saturating count of masked-valid lanes whose output was 0.

Behaviour:
- Reset, asynchronous on rstn low:
  - out_data, out_mask, out_valid, zero_cnt, cfg_pending, and both stage valid flags go to 0.
  - Shadow config goes to mode 0, clip 0, shift 0.
  - FSM goes to IDLE.
  - Reset mid-operation drops all in-flight beats.
- Pipeline: two stages. S1 registers the computed lanes; S2 is the output register.
  - Latency is 2 cycles from an in_valid&in_ready edge to out_valid when out_ready is held high.
  - Throughput is 1 beat per cycle.
- Stage advance rules:
  - S2 loads when (!s2_valid | out_ready).
  - S1 advances when (!s1_valid | S2 loads).
  - in_ready = S1 advances & (state != DRAIN). This is a combinational path from out_ready, which is accepted.
- Lane arithmetic, signed IDATA_BIT, using the shadow config:
  - bypass: y = x.
  - relu: y = x<0 ? 0 : x.
  - clip: y = x<0 ? 0 : (x > cfg_clip ? cfg_clip : x); cfg_clip is zero-extended.
  - leaky: y = x<0 ? x>>>shift : x. This rounds toward -inf, so -1 stays -1.
  - No result can overflow.
  - Lanes with mask=0 output 0 and are not counted.
- zero_cnt:
  - Adds, on each S2 handshake (out_valid&out_ready), the popcount of lanes with mask=1 and y==0.
  - Saturates at all-ones.
  - cnt_clr has priority over the increment in the same cycle.
- Config FSM:
  - IDLE: no traffic. cfg_load copies cfg_* into the shadow the same cycle; the next beat uses the new value. in_valid&in_ready moves to RUN.
  - RUN: cfg_load sets cfg_pending and moves to DRAIN.
  - RUN returns to IDLE when both stages are empty with no new accept.
  - DRAIN: in_ready is forced to 0 and in-flight beats complete with the old config. When both stages are empty, copy the captured cfg (sampled at the request cycle), clear cfg_pending and go to IDLE.
  - A second cfg_load during DRAIN overwrites the captured value; the last one wins.
- Config is never applied to a beat already accepted.
- Simultaneous cfg_load and in_valid in IDLE: the config is applied first and the beat is accepted with the new config.

Decomposition:
- Package act_pkg holds:
  - the mode enum (ACT_BYPASS, ACT_RELU, ACT_CLIP, ACT_LEAKY);
  - the FSM state enum (IDLE, RUN, DRAIN).
- One sub-module, act_lane: a combinational single-lane activation of x, mode, clip, shift and mask, producing y and is_zero. It is instantiated BUS_NUM times in a generate loop.

Test Plan:
- ReLU, full mask, out_ready=1: in {-5,0,7,-128} -> out {0,0,7,0} exactly 2 cycles later, zero_cnt=3.
- Clip with cfg_clip=20: {25,-3,20,19} -> {20,0,20,19}. Leaky with shift=2: {-8,-1,12,-128} -> {-2,-1,12,-32}.
- Mask 4'b0101 with in {9,9,-9,9} in bypass -> out {9,0,-9,0}, out_mask=0101, zero_cnt unchanged.
- Backpressure: 4 back-to-back beats with out_ready low 3 cycles -> in_ready falls after 2 beats are held; all 4 beats emerge in order with no loss or duplication.
- cfg_load (mode relu->bypass) with 2 beats in flight -> cfg_pending=1 and in_ready=0 until drain; in-flight beats are relu'd; the first new beat of {-4,...} emerges as -4.
- Reset mid-stream and counter edges:
  - rstn pulsed low with out_valid=1 -> out_valid=0 and zero_cnt=0 immediately.
  - zero_cnt preset near all-ones saturates.
  - cnt_clr during an increment -> 0.
